// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Purpose: stall/flush generator for the 5-stage MIPS pipeline. It covers
// the hazards the EX forwarding unit cannot resolve: load-use, decode-stage
// branch operand dependence, data-memory wait and the multi-cycle mult/div
// unit with its HI/LO write. It also produces the D-stage branch-compare
// forward selects.
//
// Parameters:
//   MUL_LAT     cycles from mult acceptance to HI/LO write (>=2)
//   DIV_LAT     cycles from div acceptance to HI/LO write (>=2)
//   MEM_TIMEOUT consecutive memory-wait cycles before mem_timeout sets (>=1)
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rs_d, rt_d, branch_d, mfhilo_d  decode-stage sources / instruction kind
//   writereg_ex, regwrite_ex, memtoreg_ex, muldiv_start_ex,
//   muldiv_is_div_ex                EX-stage destination and control
//   writereg_mem, regwrite_mem, memtoreg_mem, mem_req_mem
//                                   MEM-stage destination and control
//   mem_ready                       data-memory acknowledge
//   stall_f/d/e/m                   hold the respective pipeline register
//   flush_e/m/w                     bubble into E/M/W
//   forward_a_d, forward_b_d        D-stage compare takes MEM ALU result
//   muldiv_busy, hilo_we            mult/div in progress / HI/LO strobe
//   mem_timeout                     sticky memory-timeout error
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int MUL_LAT     = 4,
    parameter int DIV_LAT     = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       branch_d,
    input  logic       mfhilo_d,
    input  logic [4:0] writereg_ex,
    input  logic       regwrite_ex,
    input  logic       memtoreg_ex,
    input  logic       muldiv_start_ex,
    input  logic       muldiv_is_div_ex,
    input  logic [4:0] writereg_mem,
    input  logic       regwrite_mem,
    input  logic       memtoreg_mem,
    input  logic       mem_req_mem,
    input  logic       mem_ready,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_e,
    output logic       flush_m,
    output logic       flush_w,
    output logic       forward_a_d,
    output logic       forward_b_d,
    output logic       muldiv_busy,
    output logic       hilo_we,
    output logic       mem_timeout
);

    localparam int LAT_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = (LAT_MAX > 2) ? $clog2(LAT_MAX) : 1;
    localparam int MW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [MW-1:0]    MEM_MAX  = MW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_e;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic             timeout_q, timeout_d;

    logic lwstall, brstall, memstall, mdstall_d, mdstall_e;
    logic dep_ex, dep_mem_load;

    // Register 0 is hard-wired zero, so it never creates a dependence.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // ---------------- hazard detection ----------------
    always_comb begin
        dep_ex       = reg_match(writereg_ex, rs_d) || reg_match(writereg_ex, rt_d);
        dep_mem_load = reg_match(writereg_mem, rs_d) || reg_match(writereg_mem, rt_d);
        lwstall      = memtoreg_ex && dep_ex;
        brstall      = branch_d && ((regwrite_ex && dep_ex) || (memtoreg_mem && dep_mem_load));
        memstall     = mem_req_mem && !mem_ready;
        mdstall_d    = muldiv_busy && mfhilo_d;
        mdstall_e    = muldiv_busy && muldiv_start_ex;
    end

    assign muldiv_busy = (state_q != IDLE);
    assign hilo_we     = (state_q != IDLE) && (cnt_q == '0);
    assign mem_timeout = timeout_q;

    // ---------------- stall/flush priority ----------------
    // The outputs are gated by rst_n so the pipeline sees no stalls or
    // flushes while reset is asserted, independent of input values.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        flush_w     = 1'b0;
        forward_a_d = 1'b0;
        forward_b_d = 1'b0;
        if (rst_n) begin
            forward_a_d = regwrite_mem && reg_match(writereg_mem, rs_d);
            forward_b_d = regwrite_mem && reg_match(writereg_mem, rt_d);
            if (memstall) begin
                // Whole pipe frozen; W gets a bubble so the stalled MEM op
                // is not written back twice.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (mdstall_e) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (lwstall || brstall || mdstall_d) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // ---------------- mult/div FSM next state ----------------
    // Acceptance is blocked during memstall because EX is frozen and the
    // same instruction will still be there next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (muldiv_start_ex && !memstall) begin
                    state_d = muldiv_is_div_ex ? DIV : MUL;
                    cnt_d   = muldiv_is_div_ex ? DIV_LOAD : MUL_LOAD;
                end
            end
            MUL, DIV: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- memory wait counter ----------------
    always_comb begin
        mcnt_d    = '0;
        timeout_d = timeout_q;
        if (memstall) begin
            mcnt_d    = (mcnt_q == MEM_MAX) ? mcnt_q : mcnt_q + 1'b1;
            timeout_d = timeout_q || (mcnt_d == MEM_MAX);
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcnt_q    <= mcnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// Testbench for pipeline_stall_controller. Stimulus process drives inputs
// after each rising edge, computes the expected outputs from a behavioural
// model and queues them; a monitor process pops and compares on the falling
// edge. Output vector order:
//   {stall_f,stall_d,stall_e,stall_m,flush_e,flush_m,flush_w,
//    forward_a_d,forward_b_d,muldiv_busy,hilo_we,mem_timeout}
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    localparam int MUL_LAT     = 4;
    localparam int DIV_LAT     = 32;
    localparam int MEM_TIMEOUT = 3;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs_d, rt_d, writereg_ex, writereg_mem;
    logic       branch_d, mfhilo_d, regwrite_ex, memtoreg_ex;
    logic       muldiv_start_ex, muldiv_is_div_ex;
    logic       regwrite_mem, memtoreg_mem, mem_req_mem, mem_ready;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_e, flush_m, flush_w;
    logic       forward_a_d, forward_b_d, muldiv_busy, hilo_we, mem_timeout;

    pipeline_stall_controller #(
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .mfhilo_d(mfhilo_d),
        .writereg_ex(writereg_ex), .regwrite_ex(regwrite_ex),
        .memtoreg_ex(memtoreg_ex), .muldiv_start_ex(muldiv_start_ex),
        .muldiv_is_div_ex(muldiv_is_div_ex), .writereg_mem(writereg_mem),
        .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem),
        .mem_req_mem(mem_req_mem), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .stall_m(stall_m), .flush_e(flush_e), .flush_m(flush_m),
        .flush_w(flush_w), .forward_a_d(forward_a_d),
        .forward_b_d(forward_b_d), .muldiv_busy(muldiv_busy),
        .hilo_we(hilo_we), .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       tag;
        logic [11:0] exp;
    } item_t;

    item_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cycle       = 0;
    string tag         = "reset";

    // Behavioural model state
    int md_left  = 0;   // cycles of busy remaining (0 = unit free)
    int wait_run = 0;   // consecutive memory-wait cycles
    bit to_flag  = 0;

    function automatic bit same_reg(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    task automatic clr();
        rs_d = 0; rt_d = 0; writereg_ex = 0; writereg_mem = 0;
        branch_d = 0; mfhilo_d = 0; regwrite_ex = 0; memtoreg_ex = 0;
        muldiv_start_ex = 0; muldiv_is_div_ex = 0; regwrite_mem = 0;
        memtoreg_mem = 0; mem_req_mem = 0; mem_ready = 0;
    endtask

    // Inputs are already set (at posedge+1). Predict, queue, advance model.
    task automatic step();
        bit mem_w, lw, br, busy, mdd, mde;
        bit [6:0] sf;
        bit fa, fb;
        item_t it;
        if (!rst_n) begin
            md_left = 0; wait_run = 0; to_flag = 0;
        end
        mem_w = mem_req_mem && !mem_ready;
        busy  = md_left > 0;
        lw    = memtoreg_ex && (same_reg(writereg_ex, rs_d) || same_reg(writereg_ex, rt_d));
        br    = branch_d && ((regwrite_ex && (same_reg(writereg_ex, rs_d) || same_reg(writereg_ex, rt_d)))
                || (memtoreg_mem && (same_reg(writereg_mem, rs_d) || same_reg(writereg_mem, rt_d))));
        mdd   = busy && mfhilo_d;
        mde   = busy && muldiv_start_ex;
        if (!rst_n)             sf = 7'b0000000;
        else if (mem_w)         sf = 7'b1111001;
        else if (mde)           sf = 7'b1110010;
        else if (lw || br || mdd) sf = 7'b1100100;
        else                    sf = 7'b0000000;
        fa = rst_n && regwrite_mem && same_reg(writereg_mem, rs_d);
        fb = rst_n && regwrite_mem && same_reg(writereg_mem, rt_d);
        it.cyc = cycle;
        it.tag = tag;
        it.exp = {sf, fa, fb, busy, (md_left == 1), to_flag};
        sb.push_back(it);
        @(posedge clk);
        if (rst_n) begin
            if (md_left > 0) md_left--;
            else if (muldiv_start_ex && !mem_w)
                md_left = muldiv_is_div_ex ? DIV_LAT : MUL_LAT;
            if (mem_w) begin
                wait_run++;
                if (wait_run >= MEM_TIMEOUT) to_flag = 1;
            end else begin
                wait_run = 0;
            end
        end
        #1;
        cycle++;
    endtask

    // Monitor
    always @(negedge clk) begin
        item_t it;
        logic [11:0] act;
        if (sb.size() > 0) begin
            it  = sb.pop_front();
            act = {stall_f, stall_d, stall_e, stall_m, flush_e, flush_m, flush_w,
                   forward_a_d, forward_b_d, muldiv_busy, hilo_we, mem_timeout};
            vectors++;
            if (act !== it.exp) begin
                miscompares++;
                $display("FAIL %s cyc=%0d outs actual=%b required=%b", it.tag, it.cyc, act, it.exp);
            end
        end
    end

    initial begin
        clr();
        rst_n = 1'b0;
        // Inputs that would stall if not gated by reset
        memtoreg_ex = 1; writereg_ex = 5; rs_d = 5; mem_req_mem = 1;
        regwrite_mem = 1; writereg_mem = 5;
        repeat (2) @(posedge clk);
        #1;
        step();
        clr();
        rst_n = 1'b1;
        step();

        // Load-use
        tag = "loaduse";
        clr(); memtoreg_ex = 1; writereg_ex = 5; rs_d = 5; step();
        tag = "loaduse_r0";
        writereg_ex = 0; rs_d = 0; step();

        // Branch forward vs branch stall on load in MEM
        tag = "branch_fwd";
        clr(); branch_d = 1; rt_d = 9; regwrite_mem = 1; writereg_mem = 9; step();
        tag = "branch_ldmem";
        memtoreg_mem = 1; step();

        // Mult with mfhilo waiting
        tag = "mult";
        clr(); muldiv_start_ex = 1; step();
        clr(); step();
        mfhilo_d = 1; repeat (5) step();
        clr(); step();

        // Div followed by a second div held in EX
        tag = "div2";
        clr(); muldiv_start_ex = 1; muldiv_is_div_ex = 1; step();
        repeat (DIV_LAT + 1) step();
        clr(); repeat (DIV_LAT + 2) step();

        // Memory wait with timeout, plus concurrent load-use
        tag = "memwait";
        clr(); mem_req_mem = 1; mem_ready = 0;
        memtoreg_ex = 1; writereg_ex = 7; rt_d = 7;
        repeat (3) step();
        mem_ready = 1; repeat (2) step();
        clr(); step();

        // Reset in the middle of a div, then a mult
        tag = "rst_mid_div";
        clr(); muldiv_start_ex = 1; muldiv_is_div_ex = 1; step();
        clr(); repeat (9) step();
        rst_n = 1'b0; step();
        rst_n = 1'b1; step();
        muldiv_start_ex = 1; step();
        clr(); repeat (MUL_LAT + 1) step();

        // Randomized traffic
        tag = "random";
        for (int i = 0; i < 2000; i++) begin
            rs_d             = 5'($urandom_range(0, 3));
            rt_d             = 5'($urandom_range(0, 3));
            writereg_ex      = 5'($urandom_range(0, 3));
            writereg_mem     = 5'($urandom_range(0, 3));
            branch_d         = ($urandom_range(0, 3) == 0);
            mfhilo_d         = ($urandom_range(0, 3) == 0);
            regwrite_ex      = $urandom_range(0, 1) == 1;
            memtoreg_ex      = ($urandom_range(0, 3) == 0);
            regwrite_mem     = $urandom_range(0, 1) == 1;
            memtoreg_mem     = ($urandom_range(0, 3) == 0);
            muldiv_start_ex  = ($urandom_range(0, 7) == 0);
            muldiv_is_div_ex = ($urandom_range(0, 3) == 0);
            mem_req_mem      = ($urandom_range(0, 2) == 0);
            mem_ready        = $urandom_range(0, 1) == 1;
            rst_n            = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        clr();
        step();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
